// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives imem and holds the IF/ID register.
// Handles EX redirects, hazard stalls and the sticky HALT opcode.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [6:0] HALT_OP = 7'h7f;

  logic [31:0] pc;
  logic        halt_seen;

  assign imem_addr = pc;

  // A redirect squashes the HALT sitting in decode.
  assign halt_seen = if_id_valid
                   & (if_id_instr[6:0] == HALT_OP)
                   & ~redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_id_pc    <= 32'h0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 32'h0;
    end else if (halted) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      pc          <= redirect_pc & ~32'h3;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (halt_seen) begin
      halted      <= 1'b1;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_pc    <= pc;
      if_id_instr <= imem_rdata;
      if_id_valid <= 1'b1;
      pc          <= pc + 32'd4;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the decode controller, and `if_id_instr[6:0]` drives the controller's Opcode input.
- It owns the PC and drives a combinational-read instruction memory.
- It applies branch/jump redirects from EX and hazard stalls.
- It latches the sticky halt when the fictitious HALT opcode (7'b1111111) reaches decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/halt.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- redirect  in  1  EX resolved taken branch / JAL / JALR.
- redirect_pc  in  32  target PC for redirect.
- imem_addr  out  32  instruction memory address (= pc).
- imem_rdata  in  32  instruction word at imem_addr, same cycle.
- if_id_pc  out  32  PC of the instruction held in IF/ID.
- if_id_instr  out  32  instruction held in IF/ID (feeds decode).
- if_id_valid  out  1  IF/ID holds a real (non-bubble) instruction.
- halted  out  1  sticky: core halted.
- fetch_count  out  32  number of instructions written into IF/ID with valid=1.

Behaviour:
Reset (async, immediate):
- pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, halted=0, fetch_count=0.

Halt detection (combinational):
- `halt_seen = if_id_valid & (if_id_instr[6:0]==7'b1111111) & ~redirect`.

Per rising edge, evaluated in priority order:
1. halted=1: pc, if_id_pc, fetch_count hold; if_id_instr=NOP_INSTR, if_id_valid=0. Only reset clears halted.
2. redirect=1:
   - pc = {redirect_pc[31:1],1'b0} & ~32'h3 (i.e. low two bits forced to 0).
   - IF/ID flushed: if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc unchanged.
   - Overrides stall and halt_seen: the older EX instruction wins, so the halt in ID is squashed.
3. halt_seen=1:
   - halted<=1; pc holds.
   - IF/ID loads bubble (NOP_INSTR, valid=0) so HALT decodes for exactly one cycle.
   - Ignores stall.
4. stall=1: pc, IF/ID and fetch_count all hold.
5. Otherwise:
   - if_id_pc<=pc, if_id_instr<=imem_rdata, if_id_valid<=1, pc<=pc+4, fetch_count<=fetch_count+1.

Other rules:
- imem_addr = pc, combinational. One instruction per cycle. Decode sees fetched word 1 cycle after address presentation.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0, no error.
- fetch_count wraps at 2^32.
- No fetch in the halted state; imem_addr stays at the frozen pc.
- Reset mid-operation (including mid-stall or while halted) returns to the reset state asynchronously. The first fetch is from RESET_PC on the first edge after reset deasserts.
- Misaligned redirect_pc: low two bits silently cleared, no exception.

Test Plan:
1. Reset, then 4 free-running cycles with imem returning 32'h00A00093 at every address.
   - if_id_pc sequence 0,4,8,C; pc=0x10; fetch_count=4; if_id_valid=1 from cycle 1.
2. Stall held 3 cycles at pc=0x8.
   - pc, if_id_instr, if_id_pc and fetch_count frozen.
   - On release, next edge loads pc=0x8's word and pc=0xC.
3. redirect=1, redirect_pc=0x103 together with stall=1.
   - Next cycle: pc=0x100, if_id_instr=0x00000013, if_id_valid=0.
   - Following cycle: if_id_pc=0x100, valid=1.
4. imem returns 32'h0000007F at 0x10.
   - After it enters IF/ID: next edge halted=1, if_id_valid=0.
   - pc stays 0x14 for 10 cycles; fetch_count frozen.
5. HALT in IF/ID with redirect=1, redirect_pc=0x40 on the same edge.
   - halted stays 0, pc=0x40, fetching resumes.
6. Wrap and async reset:
   - Redirect to 0xFFFFFFFC, then run: pc wraps to 0x0.
   - Assert reset mid-cycle while halted: outputs go to reset values before the next clk edge.
